// File: rtl/jtag_work_ctrl.sv
// jtag_work_ctrl
//   Host-side work/result controller sitting between the in-system
//   source/probe endpoints and the hasher core.
//   - Toggle-strobed 32-bit host commands land in shadow midstate/data regs.
//   - A commit copies the complete shadow set into the work registers and
//     offers it to the hasher over a valid/ready handshake.
//   - Nonces returned by the hasher are queued in a small FIFO that the host
//     reads (probe_nonce) and pops (command index 14).
//
// Parameters
//   FIFO_DEPTH     nonce FIFO entries, 2 or 4 (count is reported in 3 bits)
//
// Optional feature (compile-time macro)
//   CMD_PARITY_EN  when defined, src_ctrl[6] must be the even-parity bit over
//                  {src_word, src_ctrl[3:0]}; a mismatching command is dropped
//                  and counted in err_cnt.
//
// Ports
//   clk            system clock
//   reset          asynchronous active-high reset
//   src_word       command payload (host domain, quasi-static)
//   src_ctrl       [7] strobe toggle, [6] parity, [3:0] command index
//   work_valid     work offer to hasher
//   work_ready     hasher accepts work
//   work_midstate  midstate words 0..7, word0 in [31:0]
//   work_data      data words 8..10, word8 in [31:0]
//   nonce_valid    one-cycle nonce-found pulse
//   nonce          nonce accompanying nonce_valid
//   probe_nonce    FIFO head, 0 when empty
//   probe_status   {ovf_cnt, err_cnt, fifo_count, state, load_mask}
module jtag_work_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  src_word,
    input  logic [7:0]   src_ctrl,
    output logic         work_valid,
    input  logic         work_ready,
    output logic [255:0] work_midstate,
    output logic [95:0]  work_data,
    input  logic         nonce_valid,
    input  logic [31:0]  nonce,
    output logic [31:0]  probe_nonce,
    output logic [31:0]  probe_status
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [10:0] MASK_FULL = 11'h7FF;

    // Saturating 8-bit increment for the diagnostic counters.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

    // Even-parity bit: the value that makes the total number of ones even.
    function automatic logic even_parity(input logic [35:0] d);
        return ^d;
    endfunction

    // Synchroniser and strobe-edge registers.
    logic [31:0] src_word_meta_r, src_word_sync_r;
    logic [7:0]  src_ctrl_meta_r, src_ctrl_sync_r;
    logic        strobe_d_r;

    // Command decode.
    logic        strobe_s, parity_ok_s, cmd_fire_s, parity_fail_s;
    logic        cmd_write_s, cmd_pop_s, cmd_commit_s, commit_ok_s, err_inc_s;
    logic [3:0]  cmd_idx_s;
    logic        unused_ctrl_s;

    // Shadow / work state.
    logic [31:0]  shadow_r [0:10];
    logic [10:0]  load_mask_r;
    state_t       state_r;
    logic         work_valid_r;
    logic [255:0] work_midstate_r;
    logic [95:0]  work_data_r;
    logic [7:0]   err_cnt_r, ovf_cnt_r;

    // Nonce FIFO (shift style: entry 0 is always the head).
    logic [31:0] fifo_mem_r  [0:FIFO_DEPTH-1];
    logic [31:0] fifo_next_s [0:FIFO_DEPTH-1];
    logic [2:0]  fifo_cnt_r, fifo_cnt_next_s, wr_idx_s;
    logic        fifo_pop_s, fifo_push_s, fifo_full_s, fifo_ovf_s;

    // Two-flop synchronisers plus the delayed strobe bit for toggle detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_word_meta_r <= 32'd0;
            src_word_sync_r <= 32'd0;
            src_ctrl_meta_r <= 8'd0;
            src_ctrl_sync_r <= 8'd0;
            strobe_d_r      <= 1'b0;
        end else begin
            src_word_meta_r <= src_word;
            src_word_sync_r <= src_word_meta_r;
            src_ctrl_meta_r <= src_ctrl;
            src_ctrl_sync_r <= src_ctrl_meta_r;
            strobe_d_r      <= src_ctrl_sync_r[7];
        end
    end

    // Command decode: any toggle of the synced strobe bit fires one command.
    always_comb begin
        strobe_s  = src_ctrl_sync_r[7] ^ strobe_d_r;
        cmd_idx_s = src_ctrl_sync_r[3:0];
`ifdef CMD_PARITY_EN
        parity_ok_s   = (src_ctrl_sync_r[6] ==
                         even_parity({src_word_sync_r, src_ctrl_sync_r[3:0]}));
        unused_ctrl_s = ^src_ctrl_sync_r[5:4];
`else
        parity_ok_s   = 1'b1;
        unused_ctrl_s = ^{src_ctrl_sync_r[6:4], even_parity(36'd0)};
`endif
        cmd_fire_s    = strobe_s & parity_ok_s;
        parity_fail_s = strobe_s & ~parity_ok_s;
        cmd_write_s   = cmd_fire_s & (cmd_idx_s <= 4'd10);
        cmd_pop_s     = cmd_fire_s & (cmd_idx_s == 4'd14);
        cmd_commit_s  = cmd_fire_s & (cmd_idx_s == 4'd15);
        commit_ok_s   = cmd_commit_s & (state_r != ST_ISSUE) & (load_mask_r == MASK_FULL);
        // A commit is an error if the hasher still owns the offer or the set is incomplete.
        err_inc_s     = parity_fail_s |
                        (cmd_commit_s & ((state_r == ST_ISSUE) | (load_mask_r != MASK_FULL)));
    end

    // Shadow registers and load mask; the mask is sticky so single words can be rewritten.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 11; i++) begin
                shadow_r[i] <= 32'd0;
            end
            load_mask_r <= 11'd0;
        end else begin
            for (int i = 0; i < 11; i++) begin
                if (cmd_write_s && (cmd_idx_s == 4'(i))) begin
                    shadow_r[i]    <= src_word_sync_r;
                    load_mask_r[i] <= 1'b1;
                end else begin
                    shadow_r[i]    <= shadow_r[i];
                    load_mask_r[i] <= load_mask_r[i];
                end
            end
        end
    end

    // Issue FSM: owns the work registers and the registered work_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            work_valid_r    <= 1'b0;
            work_midstate_r <= 256'd0;
            work_data_r     <= 96'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_RUN: begin
                    if (commit_ok_s) begin
                        for (int i = 0; i < 8; i++) begin
                            work_midstate_r[32*i +: 32] <= shadow_r[i];
                        end
                        for (int i = 0; i < 3; i++) begin
                            work_data_r[32*i +: 32] <= shadow_r[8+i];
                        end
                        state_r      <= ST_ISSUE;
                        work_valid_r <= 1'b1;
                    end else begin
                        state_r      <= state_r;
                        work_valid_r <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (work_valid_r && work_ready) begin
                        state_r      <= ST_RUN;
                        work_valid_r <= 1'b0;
                    end else begin
                        state_r      <= ST_ISSUE;
                        work_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    work_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // FIFO next-state: pop shifts toward the head (zero-filling), push lands after the survivors.
    always_comb begin
        fifo_full_s = (fifo_cnt_r == 3'(FIFO_DEPTH));
        fifo_pop_s  = cmd_pop_s & (fifo_cnt_r != 3'd0);
        fifo_push_s = nonce_valid & (~fifo_full_s | fifo_pop_s);
        fifo_ovf_s  = nonce_valid & fifo_full_s & ~fifo_pop_s;
        wr_idx_s    = fifo_cnt_r - {2'b00, fifo_pop_s};
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_next_s[i] = fifo_mem_r[i];
        end
        if (fifo_pop_s) begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                fifo_next_s[i] = fifo_mem_r[i+1];
            end
            fifo_next_s[FIFO_DEPTH-1] = 32'd0;
        end else begin
            fifo_next_s[0] = fifo_mem_r[0];
        end
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_push_s && (wr_idx_s == 3'(i))) begin
                fifo_next_s[i] = nonce;
            end else begin
                fifo_next_s[i] = fifo_next_s[i];
            end
        end
        fifo_cnt_next_s = fifo_cnt_r + {2'b00, fifo_push_s} - {2'b00, fifo_pop_s};
    end

    // FIFO storage and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= 32'd0;
            end
            fifo_cnt_r <= 3'd0;
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= fifo_next_s[i];
            end
            fifo_cnt_r <= fifo_cnt_next_s;
        end
    end

    // Saturating error and overflow counters, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt_r <= 8'd0;
            ovf_cnt_r <= 8'd0;
        end else begin
            err_cnt_r <= err_inc_s  ? sat_inc8(err_cnt_r) : err_cnt_r;
            ovf_cnt_r <= fifo_ovf_s ? sat_inc8(ovf_cnt_r) : ovf_cnt_r;
        end
    end

    assign work_valid    = work_valid_r;
    assign work_midstate = work_midstate_r;
    assign work_data     = work_data_r;
    assign probe_nonce   = fifo_mem_r[0];
    assign probe_status  = {ovf_cnt_r, err_cnt_r, fifo_cnt_r, state_r, load_mask_r};

endmodule
